dmem_bus_arbiter: RTL and testbench

//  Shares the single data-memory bus (DataMemory_Interface) between two masters: M0 = CPU, M1 = auxiliary

---
 rtl/dmem_bus_arbiter_pkg.sv | 19 +
 rtl/dmem_bus_arbiter_rr_arbiter2.sv | 36 +++
 rtl/dmem_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared definitions for the two-master data-memory bus arbiter.
// Contains the controller state codes, the master indices and the grant encoding helper.
package dmem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return (idx == ARB_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick with a registered priority pointer.
// The pointer moves to the non-winner whenever a transfer is acknowledged.
module rr_arbiter2
    import dmem_bus_arbiter_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [1:0] iReq,
    input  logic       iAdvance,
    input  logic       iWinner,
    output logic       oValid,
    output logic       oPick
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        oValid = iReq[0] | iReq[1];
        if (iReq == 2'b11) begin
            oPick = ptr_q;
        end else begin
            oPick = iReq[1] ? ARB_M1 : ARB_M0;
        end
        ptr_d = iAdvance ? ~iWinner : ptr_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ptr_q <= ARB_M0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Shares the data-memory bus between the CPU (M0) and an auxiliary master (M1).
// One transfer at a time: winner's request is latched, driven for one cycle, then acked.
module dmem_bus_arbiter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int BE_W   = 4,
    parameter int RD_LAT = 1
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iM0Req,
    input  logic              iM0We,
    input  logic [BE_W-1:0]   iM0Be,
    input  logic [ADDR_W-1:0] iM0Addr,
    input  logic [DATA_W-1:0] iM0WData,
    output logic              oM0Ack,
    output logic [DATA_W-1:0] oM0RData,
    input  logic              iM1Req,
    input  logic              iM1We,
    input  logic [BE_W-1:0]   iM1Be,
    input  logic [ADDR_W-1:0] iM1Addr,
    input  logic [DATA_W-1:0] iM1WData,
    output logic              oM1Ack,
    output logic [DATA_W-1:0] oM1RData,
    output logic              DwReadEnable,
    output logic              DwWriteEnable,
    output logic [BE_W-1:0]   DwByteEnable,
    output logic [ADDR_W-1:0] DwAddress,
    output logic [DATA_W-1:0] DwWriteData,
    input  logic [DATA_W-1:0] DwReadData,
    output logic [1:0]        oGrant,
    output logic              oBusy,
    output logic [1:0]        oDbgState
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e        state_q;
    logic              owner_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [1:0]        grant_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              pick_valid;
    logic              pick;
    logic              pick_we;
    logic [BE_W-1:0]   pick_be;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    rr_arbiter2 u_rr (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iReq     ({iM1Req, iM0Req}),
        .iAdvance (ack0_q | ack1_q),
        .iWinner  (owner_q),
        .oValid   (pick_valid),
        .oPick    (pick)
    );

    always_comb begin
        pick_we    = (pick == ARB_M1) ? iM1We    : iM0We;
        pick_be    = (pick == ARB_M1) ? iM1Be    : iM0Be;
        pick_addr  = (pick == ARB_M1) ? iM1Addr  : iM0Addr;
        pick_wdata = (pick == ARB_M1) ? iM1WData : iM0WData;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= ARB_IDLE;
            owner_q  <= ARB_M0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            grant_q  <= 2'b00;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick;
                        we_q    <= pick_we;
                        be_q    <= pick_be;
                        addr_q  <= pick_addr;
                        wdata_q <= pick_wdata;
                        grant_q <= grant_onehot(pick);
                        wr_en_q <= pick_we;
                        rd_en_q <= ~pick_we;
                        // Writes complete in the access cycle itself.
                        ack0_q  <= pick_we & (pick == ARB_M0);
                        ack1_q  <= pick_we & (pick == ARB_M1);
                        state_q <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (we_q) begin
                        grant_q <= 2'b00;
                        state_q <= ARB_IDLE;
                    end else begin
                        cnt_q <= CNT_LOAD;
                        if (RD_LAT == 1) begin
                            ack0_q  <= (owner_q == ARB_M0);
                            ack1_q  <= (owner_q == ARB_M1);
                            state_q <= ARB_DONE;
                        end else begin
                            state_q <= ARB_WAIT;
                        end
                    end
                end
                ARB_WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        ack0_q  <= (owner_q == ARB_M0);
                        ack1_q  <= (owner_q == ARB_M1);
                        state_q <= ARB_DONE;
                    end
                end
                ARB_DONE: begin
                    if (owner_q == ARB_M0) begin
                        rdata0_q <= DwReadData;
                    end else begin
                        rdata1_q <= DwReadData;
                    end
                    grant_q <= 2'b00;
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // Slave data is only valid during DONE, so the owner sees it through a bypass
    // alongside its ack; the holding register keeps it afterwards.
    assign oM0RData = (state_q == ARB_DONE && owner_q == ARB_M0) ? DwReadData : rdata0_q;
    assign oM1RData = (state_q == ARB_DONE && owner_q == ARB_M1) ? DwReadData : rdata1_q;

    assign oM0Ack        = ack0_q;
    assign oM1Ack        = ack1_q;
    assign DwReadEnable  = rd_en_q;
    assign DwWriteEnable = wr_en_q;
    assign DwByteEnable  = be_q;
    assign DwAddress     = addr_q;
    assign DwWriteData   = wdata_q;
    assign oGrant        = grant_q;
    assign oBusy         = (state_q != ARB_IDLE);
    assign oDbgState     = state_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter with RD_LAT=3: master drivers, a delayed-read slave model,
// per-master expected-transfer queues checked on the bus and at each ack.
module tb_dmem_bus_arbiter;

    localparam int RD_LAT = 3;
    localparam logic [63:0] KEY = 64'h0123_4567_89AB_CDEF;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] addr2;
        logic [7:0]  chg;
        logic [7:0]  gap;
    } cmd_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iM0Req, iM0We, iM1Req, iM1We;
    logic [3:0]  iM0Be, iM1Be;
    logic [63:0] iM0Addr, iM0WData, iM1Addr, iM1WData;
    logic        oM0Ack, oM1Ack;
    logic [63:0] oM0RData, oM1RData;
    logic        DwReadEnable, DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [63:0] DwAddress, DwWriteData;
    logic [63:0] DwReadData = 64'h0;
    logic [1:0]  oGrant;
    logic        oBusy;
    logic [1:0]  oDbgState;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // clock / reset block
    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    dmem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .BE_W(4), .RD_LAT(RD_LAT)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iM0Req(iM0Req), .iM0We(iM0We), .iM0Be(iM0Be), .iM0Addr(iM0Addr), .iM0WData(iM0WData),
        .oM0Ack(oM0Ack), .oM0RData(oM0RData),
        .iM1Req(iM1Req), .iM1We(iM1We), .iM1Be(iM1Be), .iM1Addr(iM1Addr), .iM1WData(iM1WData),
        .oM1Ack(oM1Ack), .oM1RData(oM1RData),
        .DwReadEnable(DwReadEnable), .DwWriteEnable(DwWriteEnable), .DwByteEnable(DwByteEnable),
        .DwAddress(DwAddress), .DwWriteData(DwWriteData), .DwReadData(DwReadData),
        .oGrant(oGrant), .oBusy(oBusy), .oDbgState(oDbgState)
    );

    // slave: data for an enable in cycle e is valid only in cycle e+RD_LAT
    logic [RD_LAT-1:0] sv_v = '0;
    logic [63:0]       sv_a [RD_LAT];
    always @(posedge iCLK) begin
        sv_v     <= {sv_v[RD_LAT-2:0], DwReadEnable};
        sv_a[0]  <= DwAddress;
        for (int k = 1; k < RD_LAT; k++) sv_a[k] <= sv_a[k-1];
        DwReadData <= sv_v[RD_LAT-2] ? (sv_a[RD_LAT-2] ^ KEY) : 64'hFFFF_0000_FFFF_0000;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // scoreboard queues
    cmd_t cmd0_q[$];
    cmd_t cmd1_q[$];
    exp_t exp0_q[$];
    exp_t exp1_q[$];
    logic grant_log[$];

    function automatic int exp_size(input logic m);
        return m ? exp1_q.size() : exp0_q.size();
    endfunction

    function automatic exp_t exp_pop(input logic m);
        if (m) return exp1_q.pop_front();
        return exp0_q.pop_front();
    endfunction

    task automatic push_xfer(input logic m, input logic we, input logic [3:0] be, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [63:0] addr2, input int chg,
                             input int gap, input logic [63:0] exp_addr);
        cmd_t c;
        exp_t e;
        c = '{we: we, be: be, addr: addr, wdata: wdata, addr2: addr2, chg: 8'(chg), gap: 8'(gap)};
        e = '{we: we, be: be, addr: exp_addr, wdata: wdata, rdata: (we ? 64'h0 : (exp_addr ^ KEY))};
        if (m) begin
            cmd1_q.push_back(c);
            exp1_q.push_back(e);
        end else begin
            cmd0_q.push_back(c);
            exp0_q.push_back(e);
        end
    endtask

    // driver tasks: one master agent per index, stepped once per cycle
    logic        m_req [2];
    logic        m_we [2];
    logic [3:0]  m_be [2];
    logic [63:0] m_addr [2];
    logic [63:0] m_wdata [2];
    logic        m_act [2];
    int          m_age [2];
    int          m_wait [2];
    cmd_t        cur [2];
    logic        abort = 1'b0;

    assign iM0Req = m_req[0];   assign iM1Req = m_req[1];
    assign iM0We = m_we[0];     assign iM1We = m_we[1];
    assign iM0Be = m_be[0];     assign iM1Be = m_be[1];
    assign iM0Addr = m_addr[0]; assign iM1Addr = m_addr[1];
    assign iM0WData = m_wdata[0]; assign iM1WData = m_wdata[1];

    task automatic step_master(input int m, input logic ack);
        int qs;
        cmd_t head;
        if (abort) begin
            m_act[m]  = 1'b0;
            m_wait[m] = 0;
        end else if (m_act[m]) begin
            if (ack) begin
                m_act[m] = 1'b0;
            end else begin
                m_age[m]++;
                if (cur[m].chg != 0 && m_age[m] == int'(cur[m].chg)) m_addr[m] = cur[m].addr2;
                check("req_timeout", 64'(m_age[m] > 100), 64'd0);
                if (m_age[m] > 100) m_act[m] = 1'b0;
            end
        end
        qs = (m == 1) ? cmd1_q.size() : cmd0_q.size();
        if (!abort && !m_act[m] && qs > 0) begin
            head = (m == 1) ? cmd1_q[0] : cmd0_q[0];
            if (m_wait[m] < int'(head.gap)) begin
                m_wait[m]++;
            end else begin
                if (m == 1) void'(cmd1_q.pop_front());
                else        void'(cmd0_q.pop_front());
                cur[m]     = head;
                m_act[m]   = 1'b1;
                m_age[m]   = 0;
                m_wait[m]  = 0;
                m_we[m]    = head.we;
                m_be[m]    = head.be;
                m_addr[m]  = head.addr;
                m_wdata[m] = head.wdata;
            end
        end
        m_req[m] = m_act[m];
    endtask

    initial begin : driver
        logic [1:0] seen_ack;
        for (int m = 0; m < 2; m++) begin
            m_req[m] = 1'b0; m_we[m] = 1'b0; m_be[m] = 4'h0; m_addr[m] = 64'h0; m_wdata[m] = 64'h0;
            m_act[m] = 1'b0; m_age[m] = 0; m_wait[m] = 0;
        end
        forever begin
            @(negedge iCLK);
            seen_ack = {oM1Ack, oM0Ack};
            @(posedge iCLK);
            #1;
            step_master(0, seen_ack[0]);
            step_master(1, seen_ack[1]);
        end
    end

    // bus/ack monitor
    logic        pend_v = 1'b0;
    logic        pend_o;
    logic        pend_we;
    logic [63:0] pend_rd;
    int          pend_due;
    logic        prev_en = 1'b0;
    logic [63:0] r_m [2] = '{64'h0, 64'h0};

    always @(negedge iCLK) begin : monitor
        logic en;
        logic ow;
        exp_t e;
        if (iRST) begin
            pend_v  = 1'b0;
            prev_en = 1'b0;
            r_m[0]  = 64'h0;
            r_m[1]  = 64'h0;
        end else begin
            en = DwReadEnable | DwWriteEnable;
            if (en) begin
                check("en_exclusive", 64'(DwReadEnable & DwWriteEnable), 64'd0);
                check("en_single_cycle", 64'(prev_en), 64'd0);
                check("grant_onehot", 64'(oGrant == 2'b01 || oGrant == 2'b10), 64'd1);
                check("busy_in_access", 64'(oBusy), 64'd1);
                ow = oGrant[1];
                check("exp_available", 64'(exp_size(ow) > 0), 64'd1);
                if (exp_size(ow) > 0) begin
                    e = exp_pop(ow);
                    check("bus_we", 64'(DwWriteEnable), 64'(e.we));
                    check("bus_addr", DwAddress, e.addr);
                    check("bus_be", 64'(DwByteEnable), 64'(e.be));
                    if (e.we) check("bus_wdata", DwWriteData, e.wdata);
                    pend_v   = 1'b1;
                    pend_o   = ow;
                    pend_we  = e.we;
                    pend_rd  = e.rdata;
                    pend_due = e.we ? cyc : cyc + RD_LAT;
                    grant_log.push_back(ow);
                end
            end
            prev_en = en;
            if (oM0Ack | oM1Ack) begin
                check("ack_exclusive", 64'(oM0Ack & oM1Ack), 64'd0);
                check("ack_pending", 64'(pend_v), 64'd1);
                if (pend_v) begin
                    check("ack_owner", 64'(oM1Ack), 64'(pend_o));
                    check("ack_cycle", 64'(cyc), 64'(pend_due));
                    check("ack_grant", 64'(oGrant), 64'(pend_o ? 2'b10 : 2'b01));
                    if (!pend_we) r_m[pend_o] = pend_rd;
                    pend_v = 1'b0;
                end
            end
            check("m0_rdata", oM0RData, r_m[0]);
            check("m1_rdata", oM1RData, r_m[1]);
        end
    end

    task automatic do_reset(input int n);
        @(posedge iCLK);
        #1 iRST = 1'b1;
        repeat (n) @(posedge iCLK);
        #1 iRST = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((cmd0_q.size() > 0 || cmd1_q.size() > 0 || m_act[0] || m_act[1] || pend_v ||
                exp0_q.size() > 0 || exp1_q.size() > 0) && n < 400) begin
            @(negedge iCLK);
            n++;
        end
        check("drain_timeout", 64'(n < 400), 64'd1);
        check("exp_left", 64'(exp0_q.size() + exp1_q.size()), 64'd0);
        repeat (2) @(negedge iCLK);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [63:0] a0, a1, b1, ar;
        int gl_base;

        // reset state
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        check("rst_rd_en", 64'(DwReadEnable), 64'd0);
        check("rst_wr_en", 64'(DwWriteEnable), 64'd0);
        check("rst_be", 64'(DwByteEnable), 64'd0);
        check("rst_addr", DwAddress, 64'd0);
        check("rst_wdata", DwWriteData, 64'd0);
        check("rst_grant", 64'(oGrant), 64'd0);
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_ack0", 64'(oM0Ack), 64'd0);
        check("rst_ack1", 64'(oM1Ack), 64'd0);
        check("rst_rdata0", oM0RData, 64'd0);
        check("rst_rdata1", oM1RData, 64'd0);
        @(posedge iCLK);
        #1 iRST = 1'b0;

        // reset in the middle of an M0 read aborts it without an ack
        @(negedge iCLK);
        push_xfer(1'b0, 1'b0, 4'hF, 64'h40, 64'h0, 64'h0, 0, 0, 64'h40);
        @(negedge iCLK);
        @(negedge iCLK);
        check("abort_rd_en", 64'(DwReadEnable), 64'd1);
        @(posedge iCLK);
        #1;
        iRST  = 1'b1;
        abort = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        check("abort_dw_en", 64'(DwReadEnable | DwWriteEnable), 64'd0);
        check("abort_dw_addr", DwAddress, 64'd0);
        check("abort_dw_be", 64'(DwByteEnable), 64'd0);
        check("abort_grant", 64'(oGrant), 64'd0);
        check("abort_busy", 64'(oBusy), 64'd0);
        @(posedge iCLK);
        #1;
        iRST  = 1'b0;
        abort = 1'b0;
        repeat (3) begin
            @(negedge iCLK);
            check("abort_no_ack", 64'(oM0Ack | oM1Ack), 64'd0);
            check("abort_idle", 64'(oBusy), 64'd0);
        end

        // M0 write alone: enable and ack one cycle after the request
        @(negedge iCLK);
        push_xfer(1'b0, 1'b1, 4'hF, 64'h1000_2000, 64'hDEAD_BEEF, 64'h0, 0, 0, 64'h1000_2000);
        @(negedge iCLK);
        @(negedge iCLK);
        check("wr_enable", 64'(DwWriteEnable), 64'd1);
        check("wr_ack", 64'(oM0Ack), 64'd1);
        check("wr_grant", 64'(oGrant), 64'h1);
        @(negedge iCLK);
        check("wr_enable_off", 64'(DwWriteEnable), 64'd0);
        check("wr_ack_off", 64'(oM0Ack), 64'd0);
        check("wr_idle", 64'(oBusy), 64'd0);
        drain();

        // M1 read with 3-cycle latency
        @(negedge iCLK);
        push_xfer(1'b1, 1'b0, 4'h3, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0);
        @(negedge iCLK);
        @(negedge iCLK);
        check("rd_enable", 64'(DwReadEnable), 64'd1);
        @(negedge iCLK);
        check("rd_enable_off", 64'(DwReadEnable), 64'd0);
        check("rd_wait_busy", 64'(oBusy), 64'd1);
        check("rd_wait_addr", DwAddress, 64'h0);
        check("rd_no_early_ack", 64'(oM1Ack), 64'd0);
        @(negedge iCLK);
        check("rd_no_early_ack2", 64'(oM1Ack), 64'd0);
        @(negedge iCLK);
        check("rd_ack", 64'(oM1Ack), 64'd1);
        check("rd_data", oM1RData, KEY);
        @(negedge iCLK);
        check("rd_ack_off", 64'(oM1Ack), 64'd0);
        check("rd_data_held", oM1RData, KEY);
        drain();

        // captured values are immune to later changes; a waiting master is sampled at grant
        a0 = {32'($urandom_range(0, 65535)), 32'($urandom)};
        a1 = {32'($urandom_range(0, 65535)), 32'($urandom)};
        b1 = a1 ^ 64'h0000_0000_0000_F0F0;
        @(negedge iCLK);
        push_xfer(1'b0, 1'b0, 4'hF, a0, 64'h0, a0 ^ 64'hFFFF, 1, 0, a0);
        push_xfer(1'b1, 1'b0, 4'h5, a1, 64'h0, b1, 2, 1, b1);
        drain();

        // read then write by M0: the write ack leaves both read-data ports alone
        ar = {32'($urandom_range(0, 65535)), 32'($urandom)};
        @(negedge iCLK);
        push_xfer(1'b0, 1'b0, 4'hF, ar, 64'h0, 64'h0, 0, 0, ar);
        push_xfer(1'b0, 1'b1, 4'h9, ar + 64'h8, 64'h1122_3344_5566_7788, 64'h0, 0, 2, ar + 64'h8);
        drain();
        check("rw_m0_rdata", oM0RData, ar ^ KEY);
        check("rw_m1_rdata", oM1RData, b1 ^ KEY);

        // both masters reading continuously from reset alternate M0, M1, ...
        do_reset(2);
        gl_base = grant_log.size();
        @(negedge iCLK);
        for (int i = 0; i < 4; i++) begin
            a0 = {32'($urandom_range(0, 65535)), 32'($urandom)};
            a1 = {32'($urandom_range(0, 65535)), 32'($urandom)};
            push_xfer(1'b0, 1'b0, 4'hF, a0, 64'h0, 64'h0, 0, 0, a0);
            push_xfer(1'b1, 1'b0, 4'hF, a1, 64'h0, 64'h0, 0, 0, a1);
        end
        drain();
        check("rr_grant_count", 64'(grant_log.size() - gl_base), 64'd8);
        if (grant_log.size() >= gl_base + 8) begin
            for (int i = 0; i < 8; i++) check("rr_order", 64'(grant_log[gl_base + i]), 64'(i % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
